muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the single-issue MIPS core. It sits in the execute stage, directly downstream of the register file, and consumes the two read ports (rs on `md_a`, rt on `md_b`). It runs MULT/MULTU/DIV/DIVU over 33 cycles while the core stalls on `md_busy`, and handles MTHI/MTLO in a single cycle. MFHI/MFLO read `md_hi`/`md_lo` directly.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 25 ++
 rtl/md_signfix.sv | 14 +
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and the iteration count.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // One multiplier/quotient bit is resolved per CALC cycle.
  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide
// unit. The core side is the master, the unit is the slave.
interface muldiv_if #(parameter int WIDTH = 32);

  logic             md_start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic             md_flush;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  modport master (
    output md_start, md_op, md_a, md_b, md_flush,
    input  md_busy, md_done, md_hi, md_lo
  );

  modport slave (
    input  md_start, md_op, md_a, md_b, md_flush,
    output md_busy, md_done, md_hi, md_lo
  );

endinterface

// File: rtl/md_signfix.sv
// Conditional two's-complement negation. With negate tied to the sign bit
// it yields an absolute value; with negate tied to a sign mismatch it
// restores the sign of a magnitude result.
module md_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? ({W{1'b0}} - value) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Signed operations
// run on operand magnitudes and the sign is applied once in FIX, so the
// same shift-add / restoring shift-subtract datapath serves both
// signednesses.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  md
);

  localparam int CW = $clog2(ITER_COUNT);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               done;

  logic               in_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               accept_arith;
  logic               accept_move;
  logic               fix_write;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign in_signed = (md.md_op == OP_MULT) || (md.md_op == OP_DIV);

  // A flush in the same cycle as a request wins, so nothing is accepted.
  assign accept_arith = (state == IDLE) && md.md_start && !md.md_flush && !md.md_op[2];
  assign accept_move  = (state == IDLE) && md.md_start && !md.md_flush &&
                        ((md.md_op == OP_MTHI) || (md.md_op == OP_MTLO));
  assign fix_write    = (state == FIX) && !md.md_flush;

  md_signfix #(.W(WIDTH)) u_abs_a (
    .value  (md.md_a),
    .negate (in_signed & md.md_a[WIDTH-1]),
    .result (a_abs)
  );

  md_signfix #(.W(WIDTH)) u_abs_b (
    .value  (md.md_b),
    .negate (in_signed & md.md_b[WIDTH-1]),
    .result (b_abs)
  );

  md_signfix #(.W(2*WIDTH)) u_fix_prod (
    .value  (acc),
    .negate (sign_a ^ sign_b),
    .result (prod_fixed)
  );

  md_signfix #(.W(WIDTH)) u_fix_quo (
    .value  (acc[WIDTH-1:0]),
    .negate (sign_a ^ sign_b),
    .result (quo_fixed)
  );

  md_signfix #(.W(WIDTH)) u_fix_rem (
    .value  (acc[2*WIDTH-1:WIDTH]),
    .negate (sign_a),
    .result (rem_fixed)
  );

  // Multiply keeps {partial product, remaining multiplier bits} in acc and
  // shifts right; divide keeps {remainder, dividend/quotient} and shifts left,
  // keeping the trial subtraction only when it does not borrow.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd};
  assign acc_step  = !is_div         ? {mul_sum, acc[WIDTH-1:1]} :
                     rem_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                       {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_arith) state_next = CALC;
      CALC:    if (cnt == CW'(ITER_COUNT - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (md.md_flush) state_next = IDLE;
  end

  // Operand latch on acceptance and one iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      a_orig   <= '0;
      opnd     <= '0;
      acc      <= '0;
    end else if (accept_arith) begin
      cnt      <= '0;
      is_div   <= md.md_op[1];
      sign_a   <= in_signed & md.md_a[WIDTH-1];
      sign_b   <= in_signed & md.md_b[WIDTH-1];
      div_zero <= (md.md_b == {WIDTH{1'b0}});
      a_orig   <= md.md_a;
      opnd     <= md.md_op[1] ? b_abs : a_abs;
      acc      <= {{WIDTH{1'b0}}, (md.md_op[1] ? a_abs : b_abs)};
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      acc <= acc_step;
    end
  end

  // HI/LO change only on a sign-corrected result in FIX or on MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_write) begin
      if (is_div && div_zero) begin
        hi <= a_orig;
        lo <= {WIDTH{1'b1}};
      end else if (is_div) begin
        hi <= rem_fixed;
        lo <= quo_fixed;
      end else begin
        hi <= prod_fixed[2*WIDTH-1:WIDTH];
        lo <= prod_fixed[WIDTH-1:0];
      end
    end else if (accept_move) begin
      if (md.md_op == OP_MTHI) hi <= md.md_a;
      else                     lo <= md.md_a;
    end
  end

  // Completion pulse for exactly the cycle after a FIX write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= fix_write;
  end

  assign md.md_busy = (state != IDLE);
  assign md.md_done = done;
  assign md.md_hi   = hi;
  assign md.md_lo   = lo;

endmodule
